hs_skid_buf: RTL and testbench

HS_SKID_BUF -- requirements
Module: hs_skid_buf

---
 rtl/hs_skid_buf.sv | 136 +++++++++++++
 tb/tb_hs_skid_buf.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hs_skid_buf.sv
// rtl/hs_skid_buf.sv - two-entry registered skid buffer for a valid/ready handshake
//
// Breaks the combinational ready path between downstream and upstream.
// Every output comes straight from a flop. A second "skid" entry catches
// the single beat that upstream can still push in the cycle that ready_in
// is falling.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rstn       in   asynchronous active-low reset
//   valid_in   in   upstream beat valid
//   data_in    in   upstream payload [DATA_WD-1:0]
//   ready_in   out  upstream may transfer (registered)
//   valid_out  out  downstream beat valid (registered)
//   data_out   out  downstream payload, the main entry [DATA_WD-1:0]
//   ready_out  in   downstream accepts
//   count      out  occupancy 0..2 (registered)

module hs_skid_buf #(
    parameter int DATA_WD = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               valid_in,
    input  logic [DATA_WD-1:0] data_in,
    output logic               ready_in,
    output logic               valid_out,
    output logic [DATA_WD-1:0] data_out,
    input  logic               ready_out,
    output logic [1:0]         count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_WD-1:0] main_q, main_d;
    logic [DATA_WD-1:0] skid_q, skid_d;
    logic               valid_out_q, valid_out_d;
    logic               ready_in_q, ready_in_d;
    logic [1:0]         count_q, count_d;

    logic fire_in;

    // ready_in_q is zero in FULL, so fire_in can only occur in EMPTY or BUSY.
    assign fire_in = valid_in & ready_in_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        case (state_q)
            S_EMPTY: begin
                if (fire_in) begin
                    main_d  = data_in;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (fire_in && ready_out) begin
                    main_d = data_in;
                end else if (fire_in) begin
                    // Downstream stalled while upstream still pushed. Park the
                    // beat in skid. main must stay stable under backpressure.
                    skid_d  = data_in;
                    state_d = S_FULL;
                end else if (ready_out) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (ready_out) begin
                    main_d  = skid_q;
                    state_d = S_BUSY;
                end
            end
            default: begin
                // Unused encoding 2'b11 recovers to EMPTY.
                state_d = S_EMPTY;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered. This keeps
    // them aligned with state_q and free of any combinational input path.
    always_comb begin
        valid_out_d = 1'b0;
        ready_in_d  = 1'b1;
        count_d     = 2'd0;
        case (state_d)
            S_BUSY: begin
                valid_out_d = 1'b1;
                ready_in_d  = 1'b1;
                count_d     = 2'd1;
            end
            S_FULL: begin
                valid_out_d = 1'b1;
                ready_in_d  = 1'b0;
                count_d     = 2'd2;
            end
            default: begin
                valid_out_d = 1'b0;
                ready_in_d  = 1'b1;
                count_d     = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            valid_out_q <= 1'b0;
            ready_in_q  <= 1'b1;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            valid_out_q <= valid_out_d;
            ready_in_q  <= ready_in_d;
            count_q     <= count_d;
        end
    end

    assign ready_in  = ready_in_q;
    assign valid_out = valid_out_q;
    assign data_out  = main_q;
    assign count     = count_q;

endmodule

// File: tb/tb_hs_skid_buf.sv
// tb/tb_hs_skid_buf.sv - directed and random bench for hs_skid_buf against a queue model

module tb_hs_skid_buf;

    localparam int DW = 32;

    logic          clk;
    logic          rstn;
    logic          valid_in;
    logic [DW-1:0] data_in;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ready_out;
    logic [1:0]    count;

    int compared;
    int mismatched;

    // Reference model: the beats accepted but not yet delivered, in arrival order.
    logic [DW-1:0] mq[$];

    hs_skid_buf #(.DATA_WD(DW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .ready_out (ready_out),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare every output with what the model queue implies.
    task automatic chk_model(input string tag);
        chk({tag, ".valid_out"}, {31'd0, valid_out}, {31'd0, (mq.size() > 0)});
        chk({tag, ".ready_in"},  {31'd0, ready_in},  {31'd0, (mq.size() < 2)});
        chk({tag, ".count"},     {30'd0, count},     mq.size());
        if (mq.size() > 0)
            chk({tag, ".data_out"}, data_out, mq[0]);
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then check at the falling edge.
    task automatic step(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
        logic          fin, fout, stall;
        logic [DW-1:0] pdata;
        valid_in  = v;
        data_in   = d;
        ready_out = r;
        fin   = v && (mq.size() < 2);
        fout  = (mq.size() > 0) && r;
        stall = valid_out && !r;
        pdata = data_out;
        @(posedge clk);
        if (fout) void'(mq.pop_front());
        if (fin)  mq.push_back(d);
        @(negedge clk);
        chk_model(tag);
        if (stall) begin
            chk({tag, ".stable_valid"}, {31'd0, valid_out}, 32'd1);
            chk({tag, ".stable_data"},  data_out, pdata);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        mq.delete();
        repeat (3) @(negedge clk);
        chk("rst.valid_out", {31'd0, valid_out}, 32'd0);
        chk("rst.ready_in",  {31'd0, ready_in},  32'd1);
        chk("rst.count",     {30'd0, count},     32'd0);
        chk("rst.data_out",  data_out,           32'd0);
        rstn = 1'b1;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rstn       = 1'b0;
        valid_in   = 1'b0;
        data_in    = '0;
        ready_out  = 1'b0;

        // Reset then idle.
        do_reset();
        step("idle", 1'b0, 32'h0, 1'b1);

        // Streaming at full throughput.
        step("str1", 1'b1, 32'h1, 1'b1);
        chk("str1.data", data_out, 32'h1);
        step("str2", 1'b1, 32'h2, 1'b1);
        chk("str2.data", data_out, 32'h2);
        chk("str2.count", {30'd0, count}, 32'd1);
        step("str3", 1'b1, 32'h3, 1'b1);
        chk("str3.data", data_out, 32'h3);
        chk("str3.ready_in", {31'd0, ready_in}, 32'd1);
        step("str_end", 1'b0, 32'h0, 1'b1);
        chk("str_end.valid", {31'd0, valid_out}, 32'd0);

        // Backpressure with a refused beat.
        step("bp_a", 1'b1, 32'hA, 1'b0);
        step("bp_b", 1'b1, 32'hB, 1'b0);
        chk("bp_b.count", {30'd0, count}, 32'd2);
        chk("bp_b.ready_in", {31'd0, ready_in}, 32'd0);
        chk("bp_b.data", data_out, 32'hA);
        step("bp_c_full", 1'b1, 32'hC, 1'b0);
        chk("bp_c_full.data", data_out, 32'hA);
        step("bp_pop_a", 1'b1, 32'hC, 1'b1);
        chk("bp_pop_a.data", data_out, 32'hB);
        chk("bp_pop_a.count", {30'd0, count}, 32'd1);
        step("bp_pop_b", 1'b1, 32'hC, 1'b1);
        chk("bp_pop_b.data", data_out, 32'hC);
        step("bp_pop_c", 1'b0, 32'h0, 1'b1);
        chk("bp_pop_c.valid", {31'd0, valid_out}, 32'd0);

        // Drain from FULL.
        step("dr_fill5", 1'b1, 32'h5, 1'b0);
        step("dr_fill6", 1'b1, 32'h6, 1'b0);
        chk("dr_full.data", data_out, 32'h5);
        step("dr_1", 1'b0, 32'h0, 1'b1);
        chk("dr_1.data", data_out, 32'h6);
        chk("dr_1.count", {30'd0, count}, 32'd1);
        step("dr_2", 1'b0, 32'h0, 1'b1);
        chk("dr_2.count", {30'd0, count}, 32'd0);
        chk("dr_2.valid", {31'd0, valid_out}, 32'd0);

        // Asynchronous reset while FULL.
        step("ar_fill7", 1'b1, 32'h7, 1'b0);
        step("ar_fill8", 1'b1, 32'h8, 1'b0);
        chk("ar_full.count", {30'd0, count}, 32'd2);
        valid_in = 1'b0;
        #2 rstn = 1'b0;
        mq.delete();
        #1;
        chk("ar.valid_now", {31'd0, valid_out}, 32'd0);
        chk("ar.count_now", {30'd0, count},     32'd0);
        chk("ar.ready_now", {31'd0, ready_in},  32'd1);
        @(negedge clk);
        rstn = 1'b1;
        step("ar_after1", 1'b0, 32'h0, 1'b1);
        step("ar_after2", 1'b0, 32'h0, 1'b1);
        step("ar_accept", 1'b1, 32'h9, 1'b0);
        chk("ar_accept.data", data_out, 32'h9);
        step("ar_flush", 1'b0, 32'h0, 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            step("rnd", 1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 3) != 0 ? 1 : 0));
        end
        for (int i = 0; i < 3; i++) begin
            step("rnd_drain", 1'b0, 32'h0, 1'b1);
        end
        chk("rnd_drain.count", {30'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
